// File: rtl/fb_rect_writer_pkg.sv
// fb_rect_writer_pkg: shared constants for the framebuffer rectangle writer.
// Holds the framebuffer size defaults, the FSM state encoding and the clip helper.
package fb_rect_writer_pkg;

    localparam int PX_WIDTH_DEF  = 160;
    localparam int PX_HEIGHT_DEF = 120;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Length of a run starting at pos that still fits below lim.
    function automatic logic [7:0] clip_len(
        input logic [7:0]  pos,
        input logic [7:0]  len,
        input logic [15:0] lim
    );
        logic [15:0] room;
        if (16'(pos) >= lim) begin
            return 8'd0;
        end
        room = lim - 16'(pos);
        return (16'(len) < room) ? len : 8'(room);
    endfunction

endpackage

// File: rtl/fb_rect_writer.sv
// fb_rect_writer: fills a rectangle of framebuffer cells with one colour code.
// Ports: dclk/clr (async active-high reset); cmd_valid/cmd_ready handshake with
//   cmd_x, cmd_y, cmd_w, cmd_h, cmd_code; write port wmemaddr/wmemdata/wmemwe;
//   status busy and one-cycle done pulse.
// Build option: define FB_CLIP_EN to clip rectangles to the framebuffer edges.
module fb_rect_writer
    import fb_rect_writer_pkg::*;
#(
    parameter int PX_WIDTH  = PX_WIDTH_DEF,
    parameter int PX_HEIGHT = PX_HEIGHT_DEF
) (
    input  logic        dclk,
    input  logic        clr,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_x,
    input  logic [6:0]  cmd_y,
    input  logic [7:0]  cmd_w,
    input  logic [6:0]  cmd_h,
    input  logic [2:0]  cmd_code,
    output logic [15:0] wmemaddr,
    output logic [2:0]  wmemdata,
    output logic        wmemwe,
    output logic        busy,
    output logic        done
);

`ifdef FB_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    state_t      r_state;
    logic [7:0]  r_x;
    logic [6:0]  r_y;
    logic [7:0]  r_w;
    logic [6:0]  r_h;
    logic [2:0]  r_code;
    logic [7:0]  r_w_eff;
    logic [7:0]  r_h_eff;
    logic [7:0]  r_col;
    logic [7:0]  r_row;
    logic [15:0] r_rowbase;
    logic [15:0] r_wmemaddr;
    logic [2:0]  r_wmemdata;
    logic        r_wmemwe;
    logic        r_done;

    logic [7:0]  w_w_eff;
    logic [7:0]  w_h_eff;
    logic [15:0] w_base;
    logic [15:0] w_next_row;
    logic        w_row_end;
    logic        w_last_row;

    // Effective size from the latched command; constant-folded when clipping is off.
    assign w_w_eff = CLIP ? clip_len(r_x, r_w, 16'(PX_WIDTH))
                          : r_w;
    assign w_h_eff = CLIP ? clip_len({1'b0, r_y}, {1'b0, r_h}, 16'(PX_HEIGHT))
                          : {1'b0, r_h};

    // One-off multiply at setup; rows then advance by addition only.
    assign w_base     = 16'(r_y) * 16'(PX_WIDTH) + 16'(r_x);
    assign w_next_row = r_rowbase + 16'(PX_WIDTH);
    assign w_row_end  = (r_col == r_w_eff - 8'd1);
    assign w_last_row = (r_row == r_h_eff - 8'd1);

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            r_state    <= ST_IDLE;
            r_x        <= '0;
            r_y        <= '0;
            r_w        <= '0;
            r_h        <= '0;
            r_code     <= '0;
            r_w_eff    <= '0;
            r_h_eff    <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_rowbase  <= '0;
            r_wmemaddr <= '0;
            r_wmemdata <= '0;
            r_wmemwe   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done   <= 1'b0;
                    r_wmemwe <= 1'b0;
                    if (cmd_valid) begin
                        r_x     <= cmd_x;
                        r_y     <= cmd_y;
                        r_w     <= cmd_w;
                        r_h     <= cmd_h;
                        r_code  <= cmd_code;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_w_eff   <= w_w_eff;
                    r_h_eff   <= w_h_eff;
                    r_col     <= '0;
                    r_row     <= '0;
                    r_rowbase <= w_base;
                    if (w_w_eff == 8'd0 || w_h_eff == 8'd0) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        // First write is presented on the cycle FILL is entered.
                        r_wmemwe   <= 1'b1;
                        r_wmemaddr <= w_base;
                        r_wmemdata <= r_code;
                        r_state    <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (w_row_end) begin
                        if (w_last_row) begin
                            r_wmemwe <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= ST_DONE;
                        end else begin
                            r_col      <= '0;
                            r_row      <= r_row + 8'd1;
                            r_rowbase  <= w_next_row;
                            r_wmemaddr <= w_next_row;
                        end
                    end else begin
                        r_col      <= r_col + 8'd1;
                        r_wmemaddr <= r_rowbase + 16'(r_col) + 16'd1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (r_state == ST_IDLE) && !clr;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign wmemwe    = r_wmemwe;
    assign wmemaddr  = r_wmemaddr;
    assign wmemdata  = r_wmemdata;

endmodule

// File: tb/tb_fb_rect_writer.sv
// tb_fb_rect_writer: self-checking bench for fb_rect_writer.
// Directed and random fill commands checked cycle by cycle against a rectangle model.
module tb_fb_rect_writer;

    localparam int PX_W = 160;
    localparam int PX_H = 120;

    logic        dclk = 1'b0;
    logic        clr;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_x;
    logic [6:0]  cmd_y;
    logic [7:0]  cmd_w;
    logic [6:0]  cmd_h;
    logic [2:0]  cmd_code;
    logic [15:0] wmemaddr;
    logic [2:0]  wmemdata;
    logic        wmemwe;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    fb_rect_writer #(
        .PX_WIDTH  (PX_W),
        .PX_HEIGHT (PX_H)
    ) dut (
        .dclk      (dclk),
        .clr       (clr),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_code  (cmd_code),
        .wmemaddr  (wmemaddr),
        .wmemdata  (wmemdata),
        .wmemwe    (wmemwe),
        .busy      (busy),
        .done      (done)
    );

    always #5 dclk = ~dclk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected write addresses for a command, row-major over the clipped rectangle.
    task automatic model(input int x, input int y, input int w, input int h,
                         output int q[$]);
        int we;
        int he;
        we = w;
        he = h;
`ifdef FB_CLIP_EN
        we = (x >= PX_W) ? 0 : ((w < PX_W - x) ? w : PX_W - x);
        he = (y >= PX_H) ? 0 : ((h < PX_H - y) ? h : PX_H - y);
`endif
        q = {};
        for (int r = 0; r < he; r++)
            for (int c = 0; c < we; c++)
                q.push_back(((y + r) * PX_W + x + c) % 65536);
    endtask

    // Called at a negedge. Issues a command and checks every cycle to completion.
    task automatic run_cmd(input int x, input int y, input int w, input int h,
                           input int code, input bit hold);
        int q[$];
        int cyc;
        model(x, y, w, h, q);
        cmd_x     = 8'(x);
        cmd_y     = 7'(y);
        cmd_w     = 8'(w);
        cmd_h     = 7'(h);
        cmd_code  = 3'(code);
        cmd_valid = 1'b1;
        cyc = 0;
        while (cmd_ready !== 1'b1 && cyc < 200) begin
            @(negedge dclk);
            cyc++;
        end
        if (cmd_ready !== 1'b1) begin
            check("accept_timeout", 32'(cmd_ready), 1);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge dclk);
        cmd_valid = hold;
        cmd_x     = 8'($urandom);
        cmd_y     = 7'($urandom);
        cmd_w     = 8'($urandom);
        cmd_h     = 7'($urandom);
        cmd_code  = 3'($urandom);
        check("setup_busy", 32'(busy), 1);
        check("setup_rdy", 32'(cmd_ready), 0);
        check("setup_we", 32'(wmemwe), 0);
        foreach (q[i]) begin
            @(negedge dclk);
            check("fill_we", 32'(wmemwe), 1);
            check("fill_addr", 32'(wmemaddr), 32'(q[i]));
            check("fill_data", 32'(wmemdata), 32'(code));
            check("fill_done", 32'(done), 0);
            check("fill_rdy", 32'(cmd_ready), 0);
        end
        @(negedge dclk);
        check("done_pulse", 32'(done), 1);
        check("done_we", 32'(wmemwe), 0);
        check("done_rdy", 32'(cmd_ready), 0);
        @(negedge dclk);
        check("end_done", 32'(done), 0);
        check("end_rdy", 32'(cmd_ready), 1);
        check("end_busy", 32'(busy), 0);
        check("end_we", 32'(wmemwe), 0);
    endtask

    task automatic reset_mid_fill();
        cmd_x     = 8'd5;
        cmd_y     = 7'd5;
        cmd_w     = 8'd4;
        cmd_h     = 7'd4;
        cmd_code  = 3'd6;
        cmd_valid = 1'b1;
        check("rst_pre_rdy", 32'(cmd_ready), 1);
        @(negedge dclk);
        cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge dclk);
            check("rst_pre_we", 32'(wmemwe), 1);
            check("rst_pre_addr", 32'(wmemaddr), 32'(5 * PX_W + 5 + k));
        end
        #2 clr = 1'b1;
        #1;
        check("rst_we", 32'(wmemwe), 0);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rdy_held", 32'(cmd_ready), 0);
        check("rst_addr", 32'(wmemaddr), 0);
        check("rst_data", 32'(wmemdata), 0);
        repeat (2) @(negedge dclk);
        check("rst_hold_we", 32'(wmemwe), 0);
        clr = 1'b0;
        #1;
        check("rst_rel_rdy", 32'(cmd_ready), 1);
        for (int k = 0; k < 16; k++) begin
            @(negedge dclk);
            check("post_rst_we", 32'(wmemwe), 0);
            check("post_rst_done", 32'(done), 0);
        end
    endtask

    initial begin
        clr       = 1'b1;
        cmd_valid = 1'b0;
        cmd_x     = '0;
        cmd_y     = '0;
        cmd_w     = '0;
        cmd_h     = '0;
        cmd_code  = '0;
        #1;
        check("reset_we", 32'(wmemwe), 0);
        check("reset_done", 32'(done), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_rdy", 32'(cmd_ready), 0);
        check("reset_addr", 32'(wmemaddr), 0);
        check("reset_data", 32'(wmemdata), 0);
        repeat (3) @(negedge dclk);
        clr = 1'b0;
        #1;
        check("reset_rel_rdy", 32'(cmd_ready), 1);
        @(negedge dclk);

        run_cmd(0, 0, 1, 1, 3, 1'b0);
        run_cmd(10, 2, 3, 2, 1, 1'b0);
        run_cmd(158, 119, 5, 4, 5, 1'b0);
        run_cmd(20, 20, 0, 5, 2, 1'b0);
        run_cmd(20, 20, 5, 0, 2, 1'b0);
        run_cmd(159, 0, 1, 3, 7, 1'b0);

        reset_mid_fill();
        run_cmd(7, 9, 4, 4, 4, 1'b0);

        run_cmd(30, 40, 3, 2, 6, 1'b1);
        run_cmd(31, 41, 2, 3, 2, 1'b0);

        for (int i = 0; i < 12; i++) begin
            run_cmd(int'($urandom_range(0, 180)), int'($urandom_range(0, 127)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
        cmd_valid = 1'b0;
        repeat (2) @(negedge dclk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
